ram_clear_ctrl: RTL
===================

Name: ram_clear_ctrl

Overview:
Parametrised single-port synchronous RAM with a req/ready access handshake, a registered read port with a valid strobe, and a built-in clear sequencer. The sequencer fills every location with INIT_VALUE after reset and on request. It replaces the fixed 32x4 switch-driven RAM in the lab datapaths. It sits between user/FSM logic and storage, so no downstream logic ever reads uninitialised memory.

Parameters:
DATA_W, 4, word width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
INIT_VALUE, 0, word written to every location by the clear sequencer (DATA_W bits)
WRITE_THROUGH, 0, 1 = an accepted write also updates q and pulses q_valid

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
req  input  1  access request, sampled each rising edge
wren  input  1  with req: 1 = write, 0 = read
address  input  ADDR_W  access address
data  input  DATA_W  write data
clear  input  1  single-cycle request to re-initialise the whole memory
ready  output  1  access accepted this cycle when req & ready
busy  output  1  clear sequencer active
q  output  DATA_W  registered read data, held between reads
q_valid  output  1  one-cycle strobe: q updated this cycle

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is asynchronous and active-high.
- Reset values: state=CLEAR, clr_addr=0, q=0, q_valid=0. Memory array has no reset; its contents are overwritten by the sequencer.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - busy=1, ready=0.
  - Each cycle: mem[clr_addr] <= INIT_VALUE, then clr_addr++.
  - When clr_addr==DEPTH-1 is written, next state is IDLE and clr_addr returns to 0.
  - Takes exactly DEPTH cycles from reset deassertion or clear acceptance.
- IDLE:
  - busy=0.
  - ready = !clear (combinational), so clear wins over a simultaneous req; that req is dropped and the requester must retry.
- clear=1 in IDLE: next state is CLEAR, clr_addr=0.
- clear=1 while in CLEAR: clr_addr restarts at 0, giving a full DEPTH more cycles.
- Accepted write (req & ready & wren): mem[address] <= data at that edge.
  - WRITE_THROUGH=1: q <= data and q_valid=1 in the following cycle.
  - WRITE_THROUGH=0: q holds and q_valid=0.
- Accepted read (req & ready & !wren):
  - q <= mem[address]; q_valid=1 in the cycle after acceptance (latency 1).
  - Back-to-back reads give back-to-back strobes.
  - A read immediately after a write to the same address returns the new data.
- q_valid is 0 in every cycle not following an accepted read, or an accepted write with WRITE_THROUGH=1. q holds its last value in those cycles and through CLEAR.
- Reset mid-operation: immediate return to the reset values; the clear restarts from address 0 after deassertion.
- Width rules:
  - address is used unmodified; all DEPTH locations are reachable.
  - clr_addr is ADDR_W bits; the terminal compare uses DEPTH-1, with no wrap past it.
  - INIT_VALUE is truncated/extended to DATA_W.
- Latency summary:
  - read: 1 cycle.
  - clear: DEPTH cycles busy.
  - write: memory visible to a read accepted on the next cycle.

Decomposition:
- Package ram_clear_ctrl_pkg: state enum (CLEAR, IDLE), and a helper for DEPTH from ADDR_W.
- Sub-module ram_array: a plain inferred single-port synchronous RAM (DATA_W, ADDR_W; we, addr, d, q). The controller muxes the address and write data between the clear sequencer and the user port.
- FSM, clr_addr counter, ready/busy/q_valid logic stay in ram_clear_ctrl.

Test Plan:
Test configuration unless stated: DATA_W=4, ADDR_W=5, INIT_VALUE=0, WRITE_THROUGH=0.
1. Reset released -> busy=1, ready=0 for exactly 32 cycles, then ready=1. Reads of addresses 0..31 each return q=0x0 with q_valid one cycle after acceptance.
2. Write addr 5 data 0xA, then read addr 5 next cycle -> q=0xA, q_valid=1 for one cycle. A read of addr 6 -> 0x0. q holds 0xA/0x0 afterwards with q_valid=0.
3. WRITE_THROUGH=1: write addr 31 data 0x3 -> next cycle q=0x3, q_valid=1. A subsequent read of addr 31 returns 0x3.
4. After writing addr 5=0xA, assert clear and req(read addr 5) in the same cycle -> ready=0, no q_valid, busy for 32 cycles. A retried read of addr 5 returns 0x0.
5. Assert reset on cycle 10 of a clear -> q=0, q_valid=0 immediately. After release, busy lasts a full 32 cycles, and all addresses read INIT_VALUE.
6. INIT_VALUE=0xF, DATA_W=8, ADDR_W=3 -> busy for 8 cycles. Reads of addresses 0..7 return 0x0F. Write addr 7=0xC5, then read -> 0xC5.

Source files
------------

// File: rtl/ram_clear_ctrl_pkg.sv
// Shared types and helpers for the self-initialising RAM controller.
package ram_clear_ctrl_pkg;

    // Controller states: CLEAR walks every location writing the init word,
    // IDLE serves user accesses.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Number of words addressable with an address of the given width.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Plain single-port synchronous RAM with a registered read port.
// The read is read-first: q shows the word stored before a same-edge write.
module ram_array
    import ram_clear_ctrl_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write and registered read; no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= d;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/ram_clear_ctrl.sv
// Single-port RAM front end with a req/ready handshake, registered read data
// with a valid strobe, and a sequencer that fills the whole array with
// INIT_VALUE after reset and whenever clear is requested.
module ram_clear_ctrl
    import ram_clear_ctrl_pkg::*;
#(
    parameter int          DATA_W        = 4,
    parameter int          ADDR_W        = 5,
    parameter int unsigned INIT_VALUE    = 0,
    parameter int          WRITE_THROUGH = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              wren,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              clear,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] q,
    output logic              q_valid
);

    localparam int unsigned       DEPTH     = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] INIT_WORD = DATA_W'(INIT_VALUE);
    localparam bit                WT_EN     = (WRITE_THROUGH != 0);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;

    logic              accept;
    logic              rd_accept;
    logic              wr_accept;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_d;
    logic [DATA_W-1:0] mem_q;

    // rd_pend_reg marks the cycle in which mem_q carries fresh read data;
    // hold_reg keeps the last presented word so q is stable between reads.
    logic              rd_pend_reg;
    logic              q_valid_reg;
    logic [DATA_W-1:0] hold_reg;

    // State register and clear-address counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    // Next-state logic plus busy/ready; a clear always restarts the walk at 0.
    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        busy          = 1'b0;
        ready         = 1'b0;
        case (state_reg)
            CLEAR: begin
                busy = 1'b1;
                if (clear) begin
                    clr_addr_next = '0;
                end else if (clr_addr_reg == LAST_ADDR) begin
                    state_next    = IDLE;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr_reg + ADDR_W'(1);
                end
            end
            IDLE: begin
                // clear takes priority; a coincident req is simply not accepted
                ready = !clear;
                if (clear) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            default: begin
                state_next    = CLEAR;
                clr_addr_next = '0;
            end
        endcase
    end

    assign accept    = req & ready;
    assign wr_accept = accept & wren;
    assign rd_accept = accept & ~wren;

    // The sequencer owns the RAM port while busy; otherwise the user port does.
    assign mem_we   = busy | wr_accept;
    assign mem_addr = busy ? clr_addr_reg : address;
    assign mem_d    = busy ? INIT_WORD    : data;

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (mem_we),
        .addr  (mem_addr),
        .d     (mem_d),
        .q     (mem_q)
    );

    // Read-result tracking: strobe, pending flag and held output word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pend_reg <= 1'b0;
            q_valid_reg <= 1'b0;
            hold_reg    <= '0;
        end else begin
            rd_pend_reg <= rd_accept;
            q_valid_reg <= rd_accept | (wr_accept & WT_EN);
            if (wr_accept && WT_EN) begin
                hold_reg <= data;
            end else if (rd_pend_reg) begin
                hold_reg <= mem_q;
            end
        end
    end

    assign q       = rd_pend_reg ? mem_q : hold_reg;
    assign q_valid = q_valid_reg;

endmodule
